// File: rtl/seg_decoder_if.sv
// Bus between a 7-segment sampler and the seg_decoder: the sampled two-digit
// pattern goes in, and the decoded value and status come out.
interface seg_decoder_if;
  logic        seg_valid;
  logic [13:0] segments;
  logic [5:0]  number;
  logic        num_valid;
  logic        decode_err;
  logic [7:0]  err_count;

  modport master (
    output seg_valid, segments,
    input  number, num_valid, decode_err, err_count
  );

  modport slave (
    input  seg_valid, segments,
    output number, num_valid, decode_err, err_count
  );
endinterface

// File: rtl/seg_decoder.sv
// Debounced two-digit 7-segment decoder. A pattern must stay identical for
// STABLE_CYCLES valid samples before it is decoded once into a value from 0 to 59.
module seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  seg_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [13:0] held, held_next;
  logic        decode;

  logic [5:0]  number_q, number_next;
  logic        num_valid_q, num_valid_next;
  logic        decode_err_q, decode_err_next;
  logic [7:0]  err_count_q, err_count_next;

  // 4'hF marks a pattern that is not in the digit table.
  function automatic logic [3:0] seg_digit(input logic [6:0] pat);
    case (pat)
      7'b1111110: return 4'd0;
      7'b0110000: return 4'd1;
      7'b1101101: return 4'd2;
      7'b1111001: return 4'd3;
      7'b0110011: return 4'd4;
      7'b1011011: return 4'd5;
      7'b1011111: return 4'd6;
      7'b1110000: return 4'd7;
      7'b1111111: return 4'd8;
      7'b1111011: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  logic [3:0] tens, units;
  logic       legal;
  logic [5:0] value;

  assign tens  = seg_digit(bus.segments[13:7]);
  assign units = seg_digit(bus.segments[6:0]);
  assign legal = (tens <= 4'd5) && (units <= 4'd9);
  assign value = 6'(tens) * 6'd10 + 6'(units);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register updates from pre-edge values.
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      held         <= '0;
      number_q     <= '0;
      num_valid_q  <= 1'b0;
      decode_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      held         <= held_next;
      number_q     <= number_next;
      num_valid_q  <= num_valid_next;
      decode_err_q <= decode_err_next;
      err_count_q  <= err_count_next;
    end
  end

  // A decode fires on the sample that completes the run, including a fresh capture
  // when a single sample is enough.
  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    held_next  = held;
    decode     = 1'b0;
    if (!bus.seg_valid) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state == IDLE || bus.segments != held) begin
      held_next  = bus.segments;
      cnt_next   = 4'd1;
      state_next = TRACK;
      if (STABLE_CNT == 4'd1) begin
        decode     = 1'b1;
        state_next = LOCKED;
      end
    end else if (state == TRACK) begin
      cnt_next = cnt + 4'd1;
      if (cnt + 4'd1 == STABLE_CNT) begin
        decode     = 1'b1;
        state_next = LOCKED;
      end
    end
  end

  always_comb begin
    number_next     = number_q;
    num_valid_next  = 1'b0;
    decode_err_next = 1'b0;
    err_count_next  = err_count_q;
    if (decode) begin
      if (legal) begin
        number_next    = value;
        num_valid_next = 1'b1;
      end else begin
        decode_err_next = 1'b1;
        if (err_count_q != 8'hFF) err_count_next = err_count_q + 8'd1;
      end
    end
  end

  assign bus.number     = number_q;
  assign bus.num_valid  = num_valid_q;
  assign bus.decode_err = decode_err_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: two instances (STABLE_CYCLES 4 and 1) share one stimulus
// stream and are compared against a run-length model built on the digit table.
module tb_seg_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_decoder_if bus4 ();
  seg_decoder_if bus1 ();

  seg_decoder #(.STABLE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  seg_decoder #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  localparam logic [6:0] DIG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011};
  localparam int M_S [2] = '{4, 1};

  int vectors = 0;
  int miscompares = 0;

  // Model state, index 0 tracks dut4 and index 1 tracks dut1.
  int          m_run  [2];
  logic [13:0] m_prev [2];
  logic [5:0]  m_num  [2];
  logic        m_nv   [2];
  logic        m_de   [2];
  int          m_err  [2];

  logic [5:0] o_num [2];
  logic       o_nv  [2];
  logic       o_de  [2];
  logic [7:0] o_err [2];
  assign o_num[0] = bus4.number;     assign o_num[1] = bus1.number;
  assign o_nv[0]  = bus4.num_valid;  assign o_nv[1]  = bus1.num_valid;
  assign o_de[0]  = bus4.decode_err; assign o_de[1]  = bus1.decode_err;
  assign o_err[0] = bus4.err_count;  assign o_err[1] = bus1.err_count;

  function automatic int digit_of(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (DIG[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [13:0] enc(input int val);
    return {DIG[val / 10], DIG[val % 10]};
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [13:0] s);
    int t, u;
    for (int k = 0; k < 2; k++) begin
      m_nv[k] = 1'b0;
      m_de[k] = 1'b0;
      if (r) begin
        m_run[k] = 0; m_prev[k] = '0; m_num[k] = '0; m_err[k] = 0;
      end else if (!v) begin
        m_run[k] = 0;
      end else begin
        if (m_run[k] > 0 && s == m_prev[k]) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : 1000;
        else m_run[k] = 1;
        m_prev[k] = s;
        if (m_run[k] == M_S[k]) begin
          t = digit_of(s[13:7]);
          u = digit_of(s[6:0]);
          if (t >= 0 && t <= 5 && u >= 0) begin
            m_num[k] = 6'(t * 10 + u);
            m_nv[k]  = 1'b1;
          end else begin
            m_de[k] = 1'b1;
            if (m_err[k] < 255) m_err[k]++;
          end
        end
      end
    end
  endtask

  // Apply one sample to both instances across one rising edge, then sample 1 ns later.
  task automatic drive(input logic r, input logic v, input logic [13:0] s);
    reset = r;
    bus4.seg_valid = v; bus4.segments = s;
    bus1.seg_valid = v; bus1.segments = s;
    @(posedge clk);
    #1;
    model_step(r, v, s);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 14'($urandom));
    drive(1'b1, 1'b0, 14'($urandom));
    vectors++;
    if (bus4.number !== 6'd0) begin miscompares++; $display("FAIL reset_number got %0d want 0", bus4.number); end
    vectors++;
    if (bus4.num_valid !== 1'b0 || bus4.decode_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_pulses got nv=%b de=%b want 0 0", bus4.num_valid, bus4.decode_err);
    end
    vectors++;
    if (bus4.err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count got %0d want 0", bus4.err_count); end
  endtask

  task automatic test_decode_59();
    drive(1'b1, 1'b0, '0);
    for (int e = 1; e <= 5; e++) begin
      drive(1'b0, 1'b1, 14'b1011011_1111011);
      vectors++;
      if (bus4.num_valid !== (e == 4)) begin
        miscompares++; $display("FAIL d59_pulse edge %0d got %b want %b", e, bus4.num_valid, e == 4);
      end
    end
    vectors++;
    if (bus4.number !== 6'd59) begin miscompares++; $display("FAIL d59_number got %0d want 59", bus4.number); end
    vectors++;
    if (bus4.err_count !== 8'd0) begin miscompares++; $display("FAIL d59_err_count got %0d want 0", bus4.err_count); end
  endtask

  task automatic test_retrack();
    int pulses = 0;
    for (int e = 1; e <= 3; e++) begin
      drive(1'b0, 1'b1, 14'b1111110_1111110);
      pulses += int'(bus4.num_valid);
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL retrack_short got %0d pulses want 0", pulses); end
    for (int e = 1; e <= 4; e++) begin
      drive(1'b0, 1'b1, 14'b0110000_1101101);
      vectors++;
      if (bus4.num_valid !== (e == 4)) begin
        miscompares++; $display("FAIL retrack_pulse edge %0d got %b want %b", e, bus4.num_valid, e == 4);
      end
    end
    vectors++;
    if (bus4.number !== 6'd12) begin miscompares++; $display("FAIL retrack_number got %0d want 12", bus4.number); end
  endtask

  task automatic test_illegal_60();
    for (int e = 1; e <= 4; e++) drive(1'b0, 1'b1, 14'b1011111_1111110);
    vectors++;
    if (bus4.decode_err !== 1'b1 || bus4.num_valid !== 1'b0) begin
      miscompares++; $display("FAIL ill60_pulses got de=%b nv=%b want 1 0", bus4.decode_err, bus4.num_valid);
    end
    vectors++;
    if (bus4.err_count !== 8'd1) begin miscompares++; $display("FAIL ill60_err_count got %0d want 1", bus4.err_count); end
    vectors++;
    if (bus4.number !== 6'd12) begin miscompares++; $display("FAIL ill60_number got %0d want 12", bus4.number); end
    drive(1'b0, 1'b1, 14'b1011111_1111110);
    vectors++;
    if (bus4.decode_err !== 1'b0) begin miscompares++; $display("FAIL ill60_one_shot got de=%b want 0", bus4.decode_err); end
  endtask

  task automatic test_gap_and_reset();
    int pulses = 0;
    logic [13:0] p;
    p = enc(33);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, p);
    drive(1'b0, 1'b1, p);
    drive(1'b0, 1'b0, p);
    for (int e = 1; e <= 4; e++) begin
      drive(1'b0, 1'b1, p);
      pulses += int'(bus4.num_valid);
      vectors++;
      if (bus4.num_valid !== (e == 4)) begin
        miscompares++; $display("FAIL gap_pulse edge %0d got %b want %b", e, bus4.num_valid, e == 4);
      end
    end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("FAIL gap_count got %0d pulses want 1", pulses); end
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, enc(21));
    drive(1'b0, 1'b1, enc(21));
    drive(1'b1, 1'b1, enc(21));
    for (int e = 0; e < 4; e++) begin
      vectors++;
      if (bus4.number !== 6'd0 || bus4.num_valid !== 1'b0 || bus4.decode_err !== 1'b0 || bus4.err_count !== 8'd0) begin
        miscompares++;
        $display("FAIL rst_run cycle %0d got num=%0d nv=%b de=%b err=%0d want all 0",
                 e, bus4.number, bus4.num_valid, bus4.decode_err, bus4.err_count);
      end
      drive(1'b0, 1'b0, enc(21));
    end
  endtask

  task automatic test_long_hold();
    int p4 = 0;
    int p1 = 0;
    drive(1'b1, 1'b0, '0);
    for (int e = 1; e <= 20; e++) begin
      drive(1'b0, 1'b1, 14'b0110011_1110000);
      p4 += int'(bus4.num_valid);
      p1 += int'(bus1.num_valid);
      if (e == 1) begin
        vectors++;
        if (bus1.num_valid !== 1'b1) begin miscompares++; $display("FAIL s1_first_edge got %b want 1", bus1.num_valid); end
      end
    end
    vectors++;
    if (p4 !== 1 || p1 !== 1) begin miscompares++; $display("FAIL hold_count got s4=%0d s1=%0d want 1 1", p4, p1); end
    vectors++;
    if (bus4.number !== 6'd47 || bus1.number !== 6'd47) begin
      miscompares++; $display("FAIL hold_number got s4=%0d s1=%0d want 47", bus4.number, bus1.number);
    end
  endtask

  task automatic test_saturate();
    logic [13:0] p;
    drive(1'b1, 1'b0, '0);
    for (int r = 0; r < 300; r++) begin
      p = (r % 2 == 1) ? 14'h3FFF : 14'h0000;
      for (int e = 1; e <= 4; e++) begin
        drive(1'b0, 1'b1, p);
        if (e == 4) begin
          vectors++;
          if (bus4.decode_err !== 1'b1) begin miscompares++; $display("FAIL sat_pulse run %0d got %b want 1", r, bus4.decode_err); end
        end
        if (e == 1) begin
          vectors++;
          if (bus1.decode_err !== 1'b1) begin miscompares++; $display("FAIL sat_pulse_s1 run %0d got %b want 1", r, bus1.decode_err); end
        end
      end
      if (r == 99) begin
        vectors++;
        if (bus4.err_count !== 8'd100) begin miscompares++; $display("FAIL sat_mid got %0d want 100", bus4.err_count); end
      end
    end
    vectors++;
    if (bus4.err_count !== 8'd255 || bus1.err_count !== 8'd255) begin
      miscompares++; $display("FAIL sat_final got s4=%0d s1=%0d want 255", bus4.err_count, bus1.err_count);
    end
  endtask

  task automatic test_random();
    logic [13:0] p;
    int len, kind;
    p = enc(0);
    drive(1'b1, 1'b0, '0);
    for (int run = 0; run < 400; run++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)       p = enc(int'($urandom_range(0, 59)));
      else if (kind == 6) p = {DIG[$urandom_range(6, 9)], DIG[$urandom_range(0, 9)]};
      else if (kind == 7) p = 14'($urandom);
      else if (kind == 8) p = '0;
      len = int'($urandom_range(1, 7));
      for (int c = 0; c < len + 2; c++) begin
        if (c < len)                         drive($urandom_range(0, 59) == 0, 1'b1, p);
        else if ($urandom_range(0, 3) == 0)  drive(1'b0, 1'b0, 14'($urandom));
        else                                 break;
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if (o_num[k] !== m_num[k] || o_nv[k] !== m_nv[k] || o_de[k] !== m_de[k] || o_err[k] !== 8'(m_err[k])) begin
            miscompares++;
            $display("FAIL rand inst%0d got num=%0d nv=%b de=%b err=%0d want num=%0d nv=%b de=%b err=%0d",
                     k, o_num[k], o_nv[k], o_de[k], o_err[k], m_num[k], m_nv[k], m_de[k], m_err[k]);
          end
          vectors++;
          if (o_nv[k] && o_de[k]) begin miscompares++; $display("FAIL rand_exclusive inst%0d got nv=1 de=1 want not both", k); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_59();
    test_retrack();
    test_illegal_60();
    test_gap_and_reset();
    test_long_hold();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
